// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_e      : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   PORT_F / PORT_D  : requester ids (fetch / load), used for grant and last_grant
//   MEM_LATENCY_MIN/MAX, CNT_W, latency_in_range(): legal Memory latency range
//                      and the wait-counter width that covers it
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 15;
  localparam int CNT_W           = 4;

  function automatic bit latency_in_range(int lat);
    return (lat >= MEM_LATENCY_MIN) && (lat <= MEM_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the two requester handshakes and the Memory port.
//   f_req/f_addr -> f_rdata/f_rvalid : fetch requester
//   d_req/d_addr -> d_rdata/d_rvalid : load requester
//   mem_addr/mem_rstrb -> mem_rdata  : shared read-only Memory port
//   busy                             : arbiter not idle
// Modports: slave = arbiter side, master = requesters + Memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_rdata;
  logic              f_rvalid;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rstrb;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, mem_rdata,
    output f_rdata, f_rvalid, d_rdata, d_rvalid, mem_addr, mem_rstrb, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, mem_rdata,
    input  f_rdata, f_rvalid, d_rdata, d_rvalid, mem_addr, mem_rstrb, busy
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner select between fetch and load requests.
//   f_req, d_req : pending requests
//   last_grant   : winner of the previous transaction (alternation history)
//   grant_id     : PORT_F or PORT_D
//   grant_valid  : at least one request pending
// Macro ARB_ROUND_ROBIN_EN: defined -> ties alternate against last_grant;
// undefined -> fixed priority, load (D) always beats fetch (F).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_id,
  output logic grant_valid
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_valid = f_req | d_req;
    grant_id    = PORT_F;
    if (f_req && d_req) begin
      grant_id = ~last_grant;
    end else if (d_req) begin
      grant_id = PORT_D;
    end
  end
`else
  // History is irrelevant under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = f_req | d_req;
    grant_id    = d_req ? PORT_D : PORT_F;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one read-only Memory port between the fetch unit (F)
// and the load unit (D). One transaction at a time:
//   IDLE -> ISSUE (mem_rstrb) -> WAIT (MEM_LATENCY-1 cycles) -> RESP (rvalid).
// Ports:
//   clk    : system clock, posedge
//   resetn : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (requester handshakes, Memory port, busy)
// Parameters: ADDR_W, DATA_W, MEM_LATENCY (1..15).
// Macro ARB_ROUND_ROBIN_EN selects the tie policy inside mem_arb_pick.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             resetn,
  mem_port_arbiter_if.slave bus
);

  if (!latency_in_range(MEM_LATENCY)) begin : g_latency_range
    $error("mem_port_arbiter: MEM_LATENCY must be within 1..15");
  end

  arb_state_e        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              issue;
  logic              grant_id;
  logic              grant_valid;
  // Holds the winner of the transaction in flight; also the alternation history.
  logic              last_grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] rdata;

  mem_arb_pick u_pick (
    .f_req       (bus.f_req),
    .d_req       (bus.d_req),
    .last_grant  (last_grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign win_addr = (grant_id == PORT_D) ? bus.d_addr : bus.f_addr;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    issue   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = (MEM_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered Memory request: strobe is high exactly in the ISSUE cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= PORT_F;
      bus.mem_addr  <= '0;
      bus.mem_rstrb <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      bus.mem_rstrb <= issue;
      if (issue) begin
        last_grant   <= grant_id;
        bus.mem_addr <= win_addr;
      end
    end
  end

  // Response: data is a straight pass-through, qualified only by rvalid.
  assign rdata        = bus.mem_rdata;
  assign bus.f_rdata  = rdata;
  assign bus.d_rdata  = rdata;
  assign bus.f_rvalid = (state == RESP) && (last_grant == PORT_F);
  assign bus.d_rvalid = (state == RESP) && (last_grant == PORT_D);
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  // Two instances: index 0 has MEM_LATENCY=1, index 1 has MEM_LATENCY=3.
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut0 (
    .clk(clk), .resetn(resetn), .bus(b0.slave));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) dut1 (
    .clk(clk), .resetn(resetn), .bus(b1.slave));

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Requester stimulus
  logic        f_req_s [2];
  logic        d_req_s [2];
  logic [31:0] f_addr_s[2];
  logic [31:0] d_addr_s[2];
  assign b0.f_req = f_req_s[0];  assign b0.f_addr = f_addr_s[0];
  assign b0.d_req = d_req_s[0];  assign b0.d_addr = d_addr_s[0];
  assign b1.f_req = f_req_s[1];  assign b1.f_addr = f_addr_s[1];
  assign b1.d_req = d_req_s[1];  assign b1.d_addr = d_addr_s[1];

  // Observed outputs
  logic        o_rstrb[2], o_busy[2], o_fv[2], o_dv[2];
  logic [31:0] o_maddr[2], o_fd[2], o_dd[2];
  assign o_rstrb[0] = b0.mem_rstrb; assign o_rstrb[1] = b1.mem_rstrb;
  assign o_busy[0]  = b0.busy;      assign o_busy[1]  = b1.busy;
  assign o_fv[0]    = b0.f_rvalid;  assign o_fv[1]    = b1.f_rvalid;
  assign o_dv[0]    = b0.d_rvalid;  assign o_dv[1]    = b1.d_rvalid;
  assign o_maddr[0] = b0.mem_addr;  assign o_maddr[1] = b1.mem_addr;
  assign o_fd[0]    = b0.f_rdata;   assign o_fd[1]    = b1.f_rdata;
  assign o_dd[0]    = b0.d_rdata;   assign o_dd[1]    = b1.d_rdata;

  // Memory: registered data MEM_LATENCY cycles after the strobe cycle
  logic [31:0] mem [64];
  logic [31:0] p0;
  logic [31:0] p1 [3];
  always @(posedge clk) begin
    p0    <= b0.mem_rstrb ? mem[b0.mem_addr[7:2]] : 32'hBAD0_0000;
    p1[0] <= b1.mem_rstrb ? mem[b1.mem_addr[7:2]] : 32'hBAD0_0001;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign b0.mem_rdata = p0;
  assign b1.mem_rdata = p1[2];

  // Reference model: each transaction is described by its accept edge t0.
  // The cycle after edge e is cycle e+1; relative to t0 the strobe lands in
  // offset 1, rvalid in offset L+1, and a new accept is possible at edge t0+L+2.
  int          cyc;
  int          t0   [2];
  logic        win  [2];
  logic [31:0] maddr[2];
  logic        last [2];

  int total = 0;
  int bad   = 0;

  logic gq[$];
  int   gt[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic choose(logic f, logic d, logic prev);
`ifdef ARB_ROUND_ROBIN_EN
    if (f && d) return (prev == PORT_F) ? PORT_D : PORT_F;
    return d ? PORT_D : PORT_F;
`else
    return d ? PORT_D : PORT_F;
`endif
  endfunction

  task automatic model_edge();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        t0[i] = -1; maddr[i] = '0; last[i] = PORT_F;
      end else begin
        if (t0[i] >= 0 && cyc >= t0[i] + lat_of(i) + 2) t0[i] = -1;
        if (t0[i] < 0 && (f_req_s[i] || d_req_s[i])) begin
          win[i]   = choose(f_req_s[i], d_req_s[i], last[i]);
          last[i]  = win[i];
          maddr[i] = (win[i] == PORT_D) ? d_addr_s[i] : f_addr_s[i];
          t0[i]    = cyc;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int o;
      int l;
      l = lat_of(i);
      o = (t0[i] >= 0) ? (cyc - t0[i] + 1) : 0;
      chk($sformatf("rstrb%0d", i), 32'(o_rstrb[i]), 32'(o == 1));
      chk($sformatf("busy%0d", i),  32'(o_busy[i]),  32'(o >= 1 && o <= l + 1));
      chk($sformatf("fvld%0d", i),  32'(o_fv[i]),    32'(o == l + 1 && win[i] == PORT_F));
      chk($sformatf("dvld%0d", i),  32'(o_dv[i]),    32'(o == l + 1 && win[i] == PORT_D));
      chk($sformatf("maddr%0d", i), o_maddr[i],      maddr[i]);
      if (o == l + 1) begin
        if (win[i] == PORT_F) chk($sformatf("fdata%0d", i), o_fd[i], mem[maddr[i][7:2]]);
        else                  chk($sformatf("ddata%0d", i), o_dd[i], mem[maddr[i][7:2]]);
      end
    end
    if (o_dv[0]) begin gq.push_back(PORT_D); gt.push_back(cyc); end
    if (o_fv[0]) begin gq.push_back(PORT_F); gt.push_back(cyc); end
  endtask

  // One clock: model the edge, check #1 later, return at the falling edge.
  task automatic step(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      @(negedge clk);
    end
  endtask

  task automatic req_gen(inout logic req, inout logic [31:0] addr, input logic seen);
    int r;
    if (!req) begin
      if ($urandom_range(0, 1) == 1) begin
        req  = 1'b1;
        addr = $urandom_range(0, 255);
      end
    end else if (seen) begin
      req  = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 255);
    end else begin
      r = int'($urandom_range(0, 99));
      if (r < 3)      req  = 1'b0;
      else if (r < 6) addr = $urandom_range(0, 255);
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = $urandom;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      t0[i] = -1; win[i] = PORT_F; maddr[i] = '0; last[i] = PORT_F;
      f_req_s[i] = 1'b1; d_req_s[i] = 1'b0;
      f_addr_s[i] = 32'h10; d_addr_s[i] = 32'h0;
    end

    // Reset held with a pending fetch
    #2 resetn = 1'b0;
    #1;
    chk("rst_rstrb", 32'(o_rstrb[0]), 32'd0);
    chk("rst_busy",  32'(o_busy[0]),  32'd0);
    chk("rst_maddr", o_maddr[0],      32'd0);
    step(3);

    // Release; single fetch of 0x10, dropped while in ISSUE
    resetn = 1'b1;
    step(1);
    chk("fetch_rstrb", 32'(o_rstrb[0]), 32'd1);
    chk("fetch_maddr", o_maddr[0],      32'h10);
    f_req_s[0] = 1'b0; f_req_s[1] = 1'b0;
    step(1);
    chk("fetch_fvld",  32'(o_fv[0]), 32'd1);
    chk("fetch_fdata", o_fd[0],      mem[4]);
    step(6);

    // Tie with both requests held
    gq.delete(); gt.delete();
    for (int i = 0; i < 2; i++) begin
      f_req_s[i] = 1'b1; d_req_s[i] = 1'b1;
      f_addr_s[i] = 32'h24; d_addr_s[i] = 32'h38;
    end
    step(9);
    chk("tie_count", 32'(gq.size()), 32'd3);
    if (gq.size() == 3) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk("tie_g0", 32'(gq[0]), 32'(PORT_D));
      chk("tie_g1", 32'(gq[1]), 32'(PORT_F));
      chk("tie_g2", 32'(gq[2]), 32'(PORT_D));
`else
      chk("tie_g0", 32'(gq[0]), 32'(PORT_D));
      chk("tie_g1", 32'(gq[1]), 32'(PORT_D));
      chk("tie_g2", 32'(gq[2]), 32'(PORT_D));
`endif
      chk("tie_gap1", 32'(gt[1] - gt[0]), 32'd3);
      chk("tie_gap2", 32'(gt[2] - gt[1]), 32'd3);
    end
    gq.delete(); gt.delete();
    d_req_s[0] = 1'b0; d_req_s[1] = 1'b0;
    step(6);
    chk("drop_d_count", 32'(gq.size() >= 1), 32'd1);
    if (gq.size() >= 1) chk("drop_d_fserved", 32'(gq[gq.size()-1]), 32'(PORT_F));
    f_req_s[0] = 1'b0; f_req_s[1] = 1'b0;
    step(6);

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        req_gen(f_req_s[i], f_addr_s[i], o_fv[i]);
        req_gen(d_req_s[i], d_addr_s[i], o_dv[i]);
      end
      step(1);
    end

    // Reset while the latency-3 instance waits on Memory
    for (int i = 0; i < 2; i++) begin f_req_s[i] = 1'b0; d_req_s[i] = 1'b0; end
    step(6);
    d_req_s[1] = 1'b1; d_addr_s[1] = 32'h5C;
    step(1);
    d_req_s[1] = 1'b0;
    step(1);
    chk("wait_busy",  32'(o_busy[1]),  32'd1);
    chk("wait_rstrb", 32'(o_rstrb[1]), 32'd0);
    resetn = 1'b0;
    #1;
    chk("wrst_busy",  32'(o_busy[1]),  32'd0);
    chk("wrst_dvld",  32'(o_dv[1]),    32'd0);
    chk("wrst_rstrb", 32'(o_rstrb[1]), 32'd0);
    chk("wrst_maddr", o_maddr[1],      32'd0);
    step(1);
    resetn = 1'b1;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
